// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared constants and state encoding
// for the fetch-stage program-counter unit.
package pc_unit_pkg;

    localparam logic RstEnable   = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int PcAddrW     = 32;
    localparam int InstAddrBus = PcAddrW - 1;

    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_RUN   = 2'd1,
        PC_DSLOT = 2'd2,
        PC_HALT  = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_unit_next_sel.sv
// pc_next_sel: combinational priority mux that computes the
// next PC, state, target and EPC-load controls.
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(32'h0000_0180),
    parameter int DELAY_SLOT = 1
) (
    input  pc_state_e          state_q,
    input  logic [ADDR_W-1:0]  pc_q,
    input  logic [ADDR_W-1:0]  epc_q,
    input  logic [ADDR_W-1:0]  tgt_q,
    input  logic               ce_q,
    input  logic               halted_q,
    input  logic               in_dslot_q,
    input  logic               stall,
    input  logic               halt,
    input  logic               resume,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               exc_req,
    input  logic               eret,
    output pc_state_e          state_d,
    output logic [ADDR_W-1:0]  pc_d,
    output logic [ADDR_W-1:0]  tgt_d,
    output logic               ce_d,
    output logic               halted_d,
    output logic               in_dslot_d,
    output logic               epc_load,
    output logic [ADDR_W-1:0]  epc_val,
    output logic               exc_bd_val
);

    localparam logic [ADDR_W-1:0] Inc  = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] Mask = ~ADDR_W'(INST_BYTES - 1);

    logic [ADDR_W-1:0] br_al;
    logic [ADDR_W-1:0] epc_al;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_dec;

    assign br_al  = branch_addr & Mask;
    assign epc_al = epc_q & Mask;
    assign pc_inc = pc_q + Inc;
    assign pc_dec = pc_q - Inc;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        ce_d       = ce_q;
        halted_d   = halted_q;
        in_dslot_d = in_dslot_q;
        epc_load   = 1'b0;
        epc_val    = pc_q;
        exc_bd_val = 1'b0;

        unique case (state_q)
            PC_IDLE: begin
                state_d = PC_RUN;
                ce_d    = ChipEnable;
            end

            PC_RUN: begin
                if (exc_req) begin
                    epc_load = 1'b1;
                    pc_d     = EXC_VEC;
                end else if (eret) begin
                    pc_d = epc_al;
                end else if (halt) begin
                    ce_d     = ChipDisable;
                    halted_d = 1'b1;
                    state_d  = PC_HALT;
                end else if (!stall) begin
                    if (branch_taken && DELAY_SLOT != 0) begin
                        tgt_d      = br_al;
                        pc_d       = pc_inc;
                        in_dslot_d = 1'b1;
                        state_d    = PC_DSLOT;
                    end else if (branch_taken) begin
                        pc_d = br_al;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end

            PC_DSLOT: begin
                // EPC points back at the branch owning this slot
                if (exc_req) begin
                    epc_load   = 1'b1;
                    epc_val    = pc_dec;
                    exc_bd_val = 1'b1;
                    pc_d       = EXC_VEC;
                    tgt_d      = '0;
                    in_dslot_d = 1'b0;
                    state_d    = PC_RUN;
                end else if (!stall) begin
                    pc_d       = tgt_q;
                    in_dslot_d = 1'b0;
                    state_d    = PC_RUN;
                end
            end

            PC_HALT: begin
                if (exc_req) begin
                    epc_load = 1'b1;
                    pc_d     = EXC_VEC;
                    ce_d     = ChipEnable;
                    halted_d = 1'b0;
                    state_d  = PC_RUN;
                end else if (resume) begin
                    ce_d     = ChipEnable;
                    halted_d = 1'b0;
                    state_d  = PC_RUN;
                end
            end

            default: begin
                state_d = PC_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with delay slot,
// exception entry/ERET and HALT handling; registers only.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W     = InstAddrBus + 1,
    parameter int INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180),
    parameter int DELAY_SLOT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic [ADDR_W-1:0] epc,
    output logic              exc_bd,
    output logic              in_dslot,
    output logic              halted
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              exc_bd_q, exc_bd_d;
    logic              ce_q, ce_d;
    logic              halted_q, halted_d;
    logic              in_dslot_q, in_dslot_d;

    logic              epc_load;
    logic [ADDR_W-1:0] epc_val;
    logic              exc_bd_val;

    pc_next_sel #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES),
        .EXC_VEC    (EXC_VEC),
        .DELAY_SLOT (DELAY_SLOT)
    ) u_next_sel (
        .state_q      (state_q),
        .pc_q         (pc_q),
        .epc_q        (epc_q),
        .tgt_q        (tgt_q),
        .ce_q         (ce_q),
        .halted_q     (halted_q),
        .in_dslot_q   (in_dslot_q),
        .stall        (stall),
        .halt         (halt),
        .resume       (resume),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .exc_req      (exc_req),
        .eret         (eret),
        .state_d      (state_d),
        .pc_d         (pc_d),
        .tgt_d        (tgt_d),
        .ce_d         (ce_d),
        .halted_d     (halted_d),
        .in_dslot_d   (in_dslot_d),
        .epc_load     (epc_load),
        .epc_val      (epc_val),
        .exc_bd_val   (exc_bd_val)
    );

    always_comb begin
        epc_d    = epc_q;
        exc_bd_d = exc_bd_q;
        if (epc_load) begin
            epc_d    = epc_val;
            exc_bd_d = exc_bd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= PC_IDLE;
            pc_q       <= RESET_VEC;
            tgt_q      <= '0;
            epc_q      <= '0;
            exc_bd_q   <= 1'b0;
            ce_q       <= ChipDisable;
            halted_q   <= 1'b0;
            in_dslot_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            epc_q      <= epc_d;
            exc_bd_q   <= exc_bd_d;
            ce_q       <= ce_d;
            halted_q   <= halted_d;
            in_dslot_q <= in_dslot_d;
        end
    end

    assign pc       = pc_q;
    assign ce       = ce_q;
    assign epc      = epc_q;
    assign exc_bd   = exc_bd_q;
    assign in_dslot = in_dslot_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table, hand sequences and random
// stimulus on three pc_unit configurations against a reference model.
module tb_pc_unit;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DSLOT = 2;
    localparam int M_HALT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, halt, resume, br, exc, eret;
    logic [31:0] baddr;

    logic [31:0] a_pc, a_epc, b_pc, b_epc;
    logic [7:0]  c_pc, c_epc;
    logic a_ce, a_bd, a_ds, a_h;
    logic b_ce, b_bd, b_ds, b_h;
    logic c_ce, c_bd, c_ds, c_h;

    int n_chk = 0;
    int n_fail = 0;

    pc_unit #(.ADDR_W(32), .DELAY_SLOT(1)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .resume(resume), .branch_taken(br), .branch_addr(baddr),
        .exc_req(exc), .eret(eret), .pc(a_pc), .ce(a_ce),
        .epc(a_epc), .exc_bd(a_bd), .in_dslot(a_ds), .halted(a_h)
    );

    pc_unit #(.ADDR_W(32), .DELAY_SLOT(0)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .resume(resume), .branch_taken(br), .branch_addr(baddr),
        .exc_req(exc), .eret(eret), .pc(b_pc), .ce(b_ce),
        .epc(b_epc), .exc_bd(b_bd), .in_dslot(b_ds), .halted(b_h)
    );

    pc_unit #(
        .ADDR_W(8), .RESET_VEC(8'h00), .EXC_VEC(8'h80), .DELAY_SLOT(1)
    ) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .resume(resume), .branch_taken(br), .branch_addr(baddr[7:0]),
        .exc_req(exc), .eret(eret), .pc(c_pc), .ce(c_ce),
        .epc(c_epc), .exc_bd(c_bd), .in_dslot(c_ds), .halted(c_h)
    );

    typedef struct {
        int     mode;
        longint pc, epc, tgt;
        bit     ce, bd, ds, h;
    } mst_t;

    mst_t ma, mb, mc;

    function automatic longint al(input longint a);
        return a - (a % 4);
    endfunction

    task automatic mstep(input int w, input bit dsc, input longint ev,
                         inout mst_t m);
        longint md;
        md = longint'(1) << w;
        if (!rst) begin
            m.mode = M_IDLE; m.pc = 0; m.epc = 0; m.tgt = 0;
            m.ce = 0; m.bd = 0; m.ds = 0; m.h = 0;
            return;
        end
        case (m.mode)
            M_IDLE: begin m.mode = M_RUN; m.ce = 1; end
            M_RUN: begin
                if (exc) begin
                    m.epc = m.pc; m.bd = 0; m.pc = ev;
                end else if (eret) begin
                    m.pc = al(m.epc);
                end else if (halt) begin
                    m.ce = 0; m.h = 1; m.mode = M_HALT;
                end else if (stall) begin
                    m.pc = m.pc;
                end else if (br && dsc) begin
                    m.tgt = al(longint'(baddr) % md);
                    m.pc = (m.pc + 4) % md;
                    m.ds = 1; m.mode = M_DSLOT;
                end else if (br) begin
                    m.pc = al(longint'(baddr) % md);
                end else begin
                    m.pc = (m.pc + 4) % md;
                end
            end
            M_DSLOT: begin
                if (exc) begin
                    m.epc = (m.pc + md - 4) % md; m.bd = 1;
                    m.pc = ev; m.tgt = 0; m.ds = 0; m.mode = M_RUN;
                end else if (!stall) begin
                    m.pc = m.tgt; m.ds = 0; m.mode = M_RUN;
                end
            end
            default: begin
                if (exc) begin
                    m.epc = m.pc; m.bd = 0; m.pc = ev;
                    m.ce = 1; m.h = 0; m.mode = M_RUN;
                end else if (resume) begin
                    m.ce = 1; m.h = 0; m.mode = M_RUN;
                end
            end
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input logic [31:0] pc,
                       input logic ce, input logic [31:0] epc,
                       input logic bd, input logic ds, input logic h,
                       input mst_t m);
        chk({t, ".pc"}, pc, 32'(m.pc));
        chk({t, ".ce"}, 32'(ce), 32'(m.ce));
        chk({t, ".epc"}, epc, 32'(m.epc));
        chk({t, ".exc_bd"}, 32'(bd), 32'(m.bd));
        chk({t, ".in_dslot"}, 32'(ds), 32'(m.ds));
        chk({t, ".halted"}, 32'(h), 32'(m.h));
    endtask

    task automatic step();
        @(posedge clk);
        mstep(32, 1'b1, 64'h180, ma);
        mstep(32, 1'b0, 64'h180, mb);
        mstep(8, 1'b1, 64'h80, mc);
        #1;
        cmp("A", a_pc, a_ce, a_epc, a_bd, a_ds, a_h, ma);
        cmp("B", b_pc, b_ce, b_epc, b_bd, b_ds, b_h, mb);
        cmp("C", 32'(c_pc), c_ce, 32'(c_epc), c_bd, c_ds, c_h, mc);
    endtask

    task automatic drive(input logic r, s, h, re, b,
                         input logic [31:0] ba, input logic x, e);
        rst = r; stall = s; halt = h; resume = re;
        br = b; baddr = ba; exc = x; eret = e;
    endtask

    typedef struct {
        logic        r, s, h, re, b;
        logic [31:0] ba;
        logic        x, e;
        logic [31:0] pc;
        logic        ce;
        logic [31:0] epc;
        logic        bd, ds, hl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, s, h, re, b,
                       input logic [31:0] ba, input logic x, e,
                       input logic [31:0] pc, input logic ce,
                       input logic [31:0] epc,
                       input logic bd, ds, hl);
        vec_t v;
        v.r = r; v.s = s; v.h = h; v.re = re; v.b = b;
        v.ba = ba; v.x = x; v.e = e; v.pc = pc; v.ce = ce;
        v.epc = epc; v.bd = bd; v.ds = ds; v.hl = hl;
        tbl.push_back(v);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        ma = '{M_IDLE, 0, 0, 0, 0, 0, 0, 0};
        mb = ma;
        mc = ma;

        for (int i = 0; i < 3; i++)
            add(0,0,0,0,0,0,0,0, 'h0,0,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,   'h0,1,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,   'h4,1,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,   'h8,1,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,   'hc,1,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,  'h10,1,'h0,0,0,0);
        add(1,0,0,0,1,'h40,0,0, 'h14,1,'h0,0,1,0);
        add(1,0,0,0,0,0,0,0,  'h40,1,'h0,0,0,0);
        add(1,0,0,0,1,'h10,0,0, 'h44,1,'h0,0,1,0);
        add(1,0,0,0,0,0,0,0,  'h10,1,'h0,0,0,0);
        add(1,0,0,0,1,'h43,0,0, 'h14,1,'h0,0,1,0);
        add(1,0,0,0,0,0,1,0, 'h180,1,'h10,1,0,0);
        add(1,0,0,0,0,0,0,1,  'h10,1,'h10,1,0,0);
        add(1,0,0,0,0,0,0,0,  'h14,1,'h10,1,0,0);
        add(1,0,0,0,0,0,0,0,  'h18,1,'h10,1,0,0);
        add(1,0,0,0,0,0,0,0,  'h1c,1,'h10,1,0,0);
        add(1,0,0,0,0,0,0,0,  'h20,1,'h10,1,0,0);
        add(1,0,1,0,0,0,0,0,  'h20,0,'h10,1,0,1);
        add(1,0,0,0,0,0,0,0,  'h20,0,'h10,1,0,1);
        add(1,1,0,0,0,0,0,0,  'h20,0,'h10,1,0,1);
        add(1,0,0,0,1,'h80,0,0, 'h20,0,'h10,1,0,1);
        add(1,0,0,0,0,0,0,1,  'h20,0,'h10,1,0,1);
        add(1,0,0,0,0,0,0,0,  'h20,0,'h10,1,0,1);
        add(1,0,0,1,0,0,0,0,  'h20,1,'h10,1,0,0);
        add(1,0,0,0,0,0,0,0,  'h24,1,'h10,1,0,0);
        add(1,0,1,0,0,0,0,0,  'h24,0,'h10,1,0,1);
        add(1,0,0,0,0,0,1,0, 'h180,1,'h24,0,0,0);
        add(1,0,0,0,1,'h33,0,0,'h184,1,'h24,0,1,0);
        add(1,1,0,0,0,0,0,0, 'h184,1,'h24,0,1,0);
        add(1,0,1,0,0,0,0,0,  'h30,1,'h24,0,0,0);
        for (int i = 0; i < 3; i++)
            add(1,1,0,0,0,0,0,0, 'h30,1,'h24,0,0,0);
        add(1,1,0,0,1,'h80,0,0, 'h30,1,'h24,0,0,0);
        add(1,1,0,0,0,0,1,0, 'h180,1,'h30,0,0,0);
        add(1,1,0,0,0,0,0,1,  'h30,1,'h30,0,0,0);
        add(1,0,0,0,1,'h50,0,0, 'h34,1,'h30,0,1,0);
        add(1,1,0,0,0,0,1,0, 'h180,1,'h30,1,0,0);
        add(1,0,0,0,0,0,0,0, 'h184,1,'h30,1,0,0);
        add(1,0,0,0,1,'h60,0,0,'h188,1,'h30,1,1,0);
        add(0,0,0,0,0,0,0,0,   'h0,0,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,   'h0,1,'h0,0,0,0);
        add(1,0,1,0,0,0,0,0,   'h0,0,'h0,0,0,1);
        add(0,0,0,0,0,0,0,0,   'h0,0,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,   'h0,1,'h0,0,0,0);
        add(1,0,0,0,0,0,0,0,   'h4,1,'h0,0,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].re,
                  tbl[i].b, tbl[i].ba, tbl[i].x, tbl[i].e);
            step();
            chk("tbl.pc", a_pc, tbl[i].pc);
            chk("tbl.ce", 32'(a_ce), 32'(tbl[i].ce));
            chk("tbl.epc", a_epc, tbl[i].epc);
            chk("tbl.exc_bd", 32'(a_bd), 32'(tbl[i].bd));
            chk("tbl.in_dslot", 32'(a_ds), 32'(tbl[i].ds));
            chk("tbl.halted", 32'(a_h), 32'(tbl[i].hl));
        end

        // immediate redirect with alignment, and delay-slot version
        drive(1, 0, 0, 0, 1, 32'h43, 0, 0);
        step();
        chk("nods.pc", b_pc, 32'h40);
        chk("ds.pc", a_pc, 32'h8);
        chk("ds.in_dslot", 32'(a_ds), 32'h1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("ds.tgt", a_pc, 32'h40);
        chk("c.tgt", 32'(c_pc), 32'h40);

        // 8-bit wrap after an aligned branch to 0xF8
        drive(1, 0, 0, 0, 1, 32'hfb, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("wrap.f8", 32'(c_pc), 32'hf8);
        step();
        chk("wrap.fc", 32'(c_pc), 32'hfc);
        step();
        chk("wrap.00", 32'(c_pc), 32'h00);
        step();
        chk("wrap.04", 32'(c_pc), 32'h04);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(99) >= 2,
                  $urandom_range(99) < 25,
                  $urandom_range(99) < 5,
                  $urandom_range(99) < 20,
                  $urandom_range(99) < 20,
                  $urandom,
                  $urandom_range(99) < 5,
                  $urandom_range(99) < 5);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage. It supersedes the single-source PC register and adds several capabilities: configurable address width and reset/exception vectors, an optional architectural branch delay slot, exception entry and ERET return with an EPC register, stall holding, and a HALT/resume state machine. It drives the instruction-memory address (`pc`) and chip enable (`ce`), and takes redirect requests from decode/execute and the exception logic.

## Interface
Parameters:
- `ADDR_W`, 32, PC/address width in bits.
- `INST_BYTES`, 4, sequential increment; power of two.
- `RESET_VEC`, 32'h0000_0000, PC after reset.
- `EXC_VEC`, 32'h0000_0180, exception entry address.
- `DELAY_SLOT`, 1, 1 = MIPS delay-slot semantics; 0 = immediate redirect.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold PC, state and `ce` this cycle.
- `halt`  in  1  halt instruction decoded; stop fetching.
- `resume`  in  1  leave HALT.
- `branch_taken`  in  1  redirect request.
- `branch_addr`  in  ADDR_W  redirect target.
- `exc_req`  in  1  exception entry request.
- `eret`  in  1  return from exception.
- `pc`  out  ADDR_W  fetch address.
- `ce`  out  1  instruction-memory enable.
- `epc`  out  ADDR_W  saved exception PC.
- `exc_bd`  out  1  last exception was taken in a delay slot.
- `in_dslot`  out  1  current `pc` is a delay-slot fetch.
- `halted`  out  1  unit is in HALT.

## Operation
- **States:** IDLE, RUN, DSLOT, HALT.
- **Reset** (`rst`=0 at an edge): state←IDLE, `pc`←RESET_VEC, `ce`←0, `epc`←0, `exc_bd`←0, `halted`←0, `in_dslot`←0, target register←0. All inputs are ignored during reset.
- **IDLE:** the next edge moves to RUN with `ce`←1 and `pc` held. The first fetch is at RESET_VEC.
- **RUN** — requests resolve in this priority order:
  - `exc_req`: `epc`←`pc`, `exc_bd`←0, `pc`←EXC_VEC.
  - `eret`: `pc`←`epc`.
  - `halt`: `ce`←0, `halted`←1, state←HALT, `pc` held.
  - `stall`: nothing changes.
  - `branch_taken` with DELAY_SLOT=1: target←`branch_addr`, `pc`←`pc`+INST_BYTES, `in_dslot`←1, state←DSLOT.
  - `branch_taken` with DELAY_SLOT=0: `pc`←`branch_addr`.
  - Otherwise: `pc`←`pc`+INST_BYTES.
- **DSLOT:**
  - `exc_req`: `epc`←`pc`−INST_BYTES (the branch instruction), `exc_bd`←1, `pc`←EXC_VEC, pending target discarded, state←RUN.
  - `stall`: everything held, target retained.
  - Otherwise: `pc`←target, `in_dslot`←0, state←RUN.
  - `branch_taken`, `halt` and `eret` in DSLOT are ignored (architecturally illegal in a delay slot).
- **HALT:** `ce`=0 and `pc` held.
  - `exc_req`: `epc`←`pc`, `exc_bd`←0, `pc`←EXC_VEC, `ce`←1, `halted`←0, state←RUN.
  - Else `resume`: `ce`←1, `halted`←0, state←RUN; fetch restarts at the held `pc`.
  - `stall` has no effect in HALT.
- **Arithmetic:** all PC arithmetic is modulo 2^ADDR_W. Incrementing from all-ones minus INST_BYTES+1 wraps to 0 with no flag.
- **Alignment:** the low log2(INST_BYTES) bits of every loaded target (`branch_addr`, `epc` on ERET) are forced to 0.
- **Precedence:** `exc_req` beats `stall` in every state. A stall never masks an exception.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Redirect latency: a request sampled at edge N shows its target on `pc` after edge N. With DELAY_SLOT=1 a branch target appears after edge N+1, provided the delay-slot cycle is not stalled.
- `ce` falls in the same cycle that `halted` rises, and rises in the cycle that `halted` falls.
- Reset asserted mid-DSLOT or mid-HALT discards all pending state on that edge.

## Structure
- **Shared defines file** holds:
  - `RstEnable` = 1'b0
  - `ChipEnable` / `ChipDisable`
  - `InstAddrBus` (derived from ADDR_W default)
  - 2-bit state encodings: PC_IDLE=0, PC_RUN=1, PC_DSLOT=2, PC_HALT=3
- **Sub-module `pc_next_sel`:** combinational priority mux that computes the next `pc`, state and EPC-load controls. `pc_unit` keeps only the registers. The split lets the mux be formally checked for priority order.

## Test plan
- **Reset release:** hold `rst`=0 for 3 cycles, then release → `pc`=0, `ce`=0 for one cycle; next cycle `ce`=1, `pc`=0; then 4, 8, 12.
- **Delay slot (DELAY_SLOT=1):** at `pc`=0x10, `branch_taken`=1, `branch_addr`=0x40 → `pc` sequence 0x14 (`in_dslot`=1), then 0x40 (`in_dslot`=0). Same stimulus with DELAY_SLOT=0 → 0x40 directly.
- **Exception in delay slot:** at `pc`=0x14 in DSLOT assert `exc_req` → `pc`=0x180, `epc`=0x10, `exc_bd`=1. Then `eret` → `pc`=0x10.
- **Halt/resume:** `halt` at `pc`=0x20 → `ce`=0, `halted`=1, `pc` stays 0x20 for 5 cycles. `resume` → `ce`=1, then `pc` 0x20, 0x24. Repeat with `exc_req` in HALT → `pc`=0x180, `epc`=0x20.
- **Stall plus priority:** `stall` held 3 cycles at `pc`=0x30 → `pc` stays 0x30. `stall`+`branch_taken` together → `pc` held. `stall`+`exc_req` together → `pc`=0x180.
- **Wrap and alignment (ADDR_W=8):** from `pc`=0xFC, next `pc`=0x00. `branch_addr`=0x43 → loaded as 0x40.
